nn_layer_sequencer: RTL and testbench

- FSM that runs one full 784-20-20-10 inference pass over the per-neuron weight BRAMs and the shared activation (IO) BRAM.
- Generates the shared weight address and the IO read/write addresses.
- Drives the MAC array's clear, accumulate and bias strobes, then sequences writeback of the neuron results, layer by layer.
- Sits between the top-level control (start/done) and the neuron MAC array and its BRAMs.

---
 rtl/nn_layer_sequencer.sv | 171 +++++++++++++++++
 tb/tb_nn_layer_sequencer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/nn_layer_sequencer.sv
// Sequencer for one 784-20-20-10 inference pass: walks the weight/IO BRAM
// addresses, issues MAC strobes aligned to BRAM latency and writes back each layer.
//
// state | meaning
// IDLE  | waiting for start, all outputs low
// MAC   | stream inputs/weights at base+k
// BIAS  | fetch bias word at base+N_in
// DRAIN | wait RD_LAT cycles for the last data to land
// WRITE | write neuron j result to out_base+j
// DONE  | one-cycle done pulse
module nn_layer_sequencer #(
  parameter int RD_LAT = 1,
  parameter int N_MAX  = 20
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic [1:0]                 layer,
  output logic [9:0]                 weight_addr,
  output logic [9:0]                 io_addr,
  output logic                       io_we,
  output logic [$clog2(N_MAX)-1:0]   out_sel,
  output logic                       mac_clr,
  output logic                       mac_en,
  output logic                       bias_en,
  output logic                       relu_en
);

  localparam int SEL_W = $clog2(N_MAX);

  typedef enum logic [2:0] {
    S_IDLE, S_MAC, S_BIAS, S_DRAIN, S_WRITE, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [9:0]        k_q, k_d;
  logic [SEL_W-1:0]  j_q, j_d;
  logic [1:0]        layer_q, layer_d;
  logic [1:0]        drain_q, drain_d;
  logic [RD_LAT-1:0] mac_sr, bias_sr;

  logic [9:0]        base, n_in_m1, out_base;
  logic [SEL_W-1:0]  n_out_m1;
  logic              relu;

  always_comb begin
    base     = '0;
    n_in_m1  = '0;
    out_base = '0;
    n_out_m1 = '0;
    relu     = 1'b0;
    case (layer_q)
      2'd1: begin base = 10'h000; n_in_m1 = 10'd783; out_base = 10'h311; n_out_m1 = SEL_W'(19); relu = 1'b1; end
      2'd2: begin base = 10'h311; n_in_m1 = 10'd19;  out_base = 10'h326; n_out_m1 = SEL_W'(19); relu = 1'b1; end
      2'd3: begin base = 10'h326; n_in_m1 = 10'd19;  out_base = 10'h33B; n_out_m1 = SEL_W'(9);  relu = 1'b0; end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      j_q     <= '0;
      layer_q <= '0;
      drain_q <= '0;
      mac_sr  <= '0;
      bias_sr <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      j_q     <= j_d;
      layer_q <= layer_d;
      drain_q <= drain_d;
      mac_sr  <= (mac_sr << 1)  | RD_LAT'(state_q == S_MAC);
      bias_sr <= (bias_sr << 1) | RD_LAT'(state_q == S_BIAS);
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    j_d     = j_q;
    layer_d = layer_q;
    drain_d = drain_q;
    case (state_q)
      S_IDLE:
        if (start) begin
          state_d = S_MAC;
          layer_d = 2'd1;
          k_d     = '0;
        end
      S_MAC:
        if (k_q == n_in_m1) state_d = S_BIAS;
        else                k_d = k_q + 10'd1;
      S_BIAS: begin
        state_d = S_DRAIN;
        drain_d = 2'(RD_LAT - 1);
      end
      S_DRAIN:
        if (drain_q == 2'd0) begin
          state_d = S_WRITE;
          j_d     = '0;
        end else begin
          drain_d = drain_q - 2'd1;
        end
      S_WRITE:
        if (j_q == n_out_m1) begin
          if (layer_q == 2'd3) begin
            state_d = S_DONE;
          end else begin
            state_d = S_MAC;
            layer_d = layer_q + 2'd1;
            k_d     = '0;
          end
        end else begin
          j_d = j_q + SEL_W'(1);
        end
      S_DONE: begin
        state_d = S_IDLE;
        layer_d = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Address and strobe decode; BIAS/DRAIN/WRITE hold the bias address on the weight side.
  always_comb begin
    busy        = 1'b0;
    done        = 1'b0;
    layer       = '0;
    weight_addr = '0;
    io_addr     = '0;
    io_we       = 1'b0;
    out_sel     = '0;
    mac_clr     = 1'b0;
    relu_en     = 1'b0;
    case (state_q)
      S_MAC: begin
        busy        = 1'b1;
        layer       = layer_q;
        weight_addr = base + k_q;
        io_addr     = base + k_q;
        mac_clr     = (k_q == 10'd0);
      end
      S_BIAS, S_DRAIN: begin
        busy        = 1'b1;
        layer       = layer_q;
        weight_addr = base + n_in_m1 + 10'd1;
        io_addr     = base + k_q;
      end
      S_WRITE: begin
        busy        = 1'b1;
        layer       = layer_q;
        weight_addr = base + n_in_m1 + 10'd1;
        io_addr     = out_base + 10'(j_q);
        io_we       = 1'b1;
        out_sel     = j_q;
        relu_en     = relu;
      end
      S_DONE: done = 1'b1;
      default: ;
    endcase
  end

  assign mac_en  = mac_sr[RD_LAT-1];
  assign bias_en = bias_sr[RD_LAT-1];

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Directed bench: two sequencers (RD_LAT=1 and RD_LAT=3) checked against
// hand-computed cycle numbers, address ranges and writeback lists.
module tb_nn_layer_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset1, start1, reset3, start3;
  logic       busy1, done1, io_we1, mac_clr1, mac_en1, bias_en1, relu_en1;
  logic [1:0] layer1;
  logic [9:0] weight_addr1, io_addr1;
  logic [4:0] out_sel1;
  logic       busy3, done3, io_we3, mac_clr3, mac_en3, bias_en3, relu_en3;
  logic [1:0] layer3;
  logic [9:0] weight_addr3, io_addr3;
  logic [4:0] out_sel3;

  nn_layer_sequencer #(.RD_LAT(1), .N_MAX(20)) dut1 (
    .Clk(clk), .Reset(reset1), .start(start1), .busy(busy1), .done(done1),
    .layer(layer1), .weight_addr(weight_addr1), .io_addr(io_addr1), .io_we(io_we1),
    .out_sel(out_sel1), .mac_clr(mac_clr1), .mac_en(mac_en1), .bias_en(bias_en1),
    .relu_en(relu_en1));

  nn_layer_sequencer #(.RD_LAT(3), .N_MAX(20)) dut3 (
    .Clk(clk), .Reset(reset3), .start(start3), .busy(busy3), .done(done3),
    .layer(layer3), .weight_addr(weight_addr3), .io_addr(io_addr3), .io_we(io_we3),
    .out_sel(out_sel3), .mac_clr(mac_clr3), .mac_en(mac_en3), .bias_en(bias_en3),
    .relu_en(relu_en3));

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  int ob_tab   [3] = '{'h311, 'h326, 'h33B};
  int nout_tab [3] = '{20, 20, 10};
  int relu_tab [3] = '{1, 1, 0};

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] outs1();
    return 64'({busy1, done1, layer1, weight_addr1, io_addr1, io_we1, out_sel1,
                mac_clr1, mac_en1, bias_en1, relu_en1});
  endfunction

  function automatic logic [63:0] outs3();
    return 64'({busy3, done3, layer3, weight_addr3, io_addr3, io_we3, out_sel3,
                mac_clr3, mac_en3, bias_en3, relu_en3});
  endfunction

  initial begin
    int busy_rise1, done_at1, done_cnt1, busy_at_done1, addr_err, wa785, mac_l1, mac_tot;
    int first_mac3, done_at3, done_cnt3, first_we3, first_we1, idx, strobe_cnt;
    int wa401, b882, b883, l883, wa883, b_end;
    logic [1:0]  last_layer;
    int          layer_seq[$];
    int          clr_cyc[$];
    int          bias_cyc[$];
    int          done_cyc[$];
    logic [15:0] wr_q[$];

    reset1 = 1'b1; reset3 = 1'b1; start1 = 1'b0; start3 = 1'b0;
    repeat (3) step();
    chk("reset_outs1", outs1(), 64'd0);
    chk("reset_outs3", outs3(), 64'd0);
    reset1 = 1'b0; reset3 = 1'b0;
    step();
    chk("idle_outs1", outs1(), 64'd0);

    // Full pass on both instances, start at cycle 0
    busy_rise1 = 0; done_at1 = 0; done_cnt1 = 0; busy_at_done1 = 1; addr_err = 0;
    wa785 = 0; mac_l1 = 0; mac_tot = 0; first_mac3 = 0; done_at3 = 0; done_cnt3 = 0;
    first_we3 = 0; first_we1 = 0; last_layer = 2'd0;
    cyc = 0; start1 = 1'b1; start3 = 1'b1;
    step();
    start1 = 1'b0; start3 = 1'b0;
    for (int n = 0; n < 900; n++) begin
      if (busy1 && busy_rise1 == 0) busy_rise1 = cyc;
      if (done1) begin
        done_cnt1++;
        if (done_at1 == 0) begin done_at1 = cyc; busy_at_done1 = int'(busy1); end
      end
      if (layer1 != last_layer) begin layer_seq.push_back(int'(layer1)); last_layer = layer1; end
      if (cyc <= 784 && weight_addr1 !== 10'(cyc - 1)) addr_err++;
      if (mac_clr1) clr_cyc.push_back(cyc);
      if (cyc == 785) wa785 = int'(weight_addr1);
      if (bias_en1) bias_cyc.push_back(cyc);
      if (mac_en1) begin mac_tot++; if (layer1 == 2'd1) mac_l1++; end
      if (io_we1) begin
        wr_q.push_back({relu_en1, out_sel1, io_addr1});
        if (first_we1 == 0) first_we1 = cyc;
      end
      if (mac_en3 && first_mac3 == 0) first_mac3 = cyc;
      if (done3) begin done_cnt3++; if (done_at3 == 0) done_at3 = cyc; end
      if (io_we3 && first_we3 == 0) first_we3 = cyc;
      step();
    end

    chk("busy_rise", busy_rise1, 1);
    chk("done_cycle", done_at1, 881);
    chk("busy_at_done", busy_at_done1, 0);
    chk("done_count", done_cnt1, 1);
    chk("layer_seq_len", layer_seq.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < layer_seq.size()) chk($sformatf("layer_seq[%0d]", i), layer_seq[i], (i == 3) ? 0 : i + 1);
    chk("l1_addr_trace_errs", addr_err, 0);
    chk("bias_addr_l1", wa785, 'h310);
    chk("clr_count", clr_cyc.size(), 3);
    if (clr_cyc.size() == 3) begin
      chk("clr_l1_cycle", clr_cyc[0], 1);
      chk("clr_l2_cycle", clr_cyc[1], 807);
      chk("clr_l3_cycle", clr_cyc[2], 849);
    end
    chk("bias_en_count", bias_cyc.size(), 3);
    if (bias_cyc.size() > 0) chk("bias_en_l1_cycle", bias_cyc[0], 786);
    chk("mac_en_l1", mac_l1, 784);
    chk("mac_en_total", mac_tot, 824);
    chk("first_write_lat1", first_we1, 787);
    chk("write_count", wr_q.size(), 50);
    idx = 0;
    for (int l = 0; l < 3; l++)
      for (int j = 0; j < nout_tab[l]; j++) begin
        if (idx < wr_q.size())
          chk($sformatf("write_l%0d_j%0d", l + 1, j), wr_q[idx],
              {1'(relu_tab[l]), 5'(j), 10'(ob_tab[l] + j)});
        idx++;
      end
    chk("lat3_first_mac_en", first_mac3, 4);
    chk("lat3_first_write", first_we3, 789);
    chk("lat3_done_cycle", done_at3, 887);
    chk("lat3_done_count", done_cnt3, 1);

    // start held high (with a re-pulse mid-L2): one done per pass, restart only from IDLE
    b882 = 1; b883 = 0; l883 = 0; wa883 = 1;
    cyc = 0; start1 = 1'b1;
    step();
    for (int n = 0; n < 1770; n++) begin
      if (cyc == 830) start1 = 1'b0;
      if (cyc == 832) start1 = 1'b1;
      if (done1) begin
        done_cyc.push_back(cyc);
        if (done_cyc.size() == 2) start1 = 1'b0;
      end
      if (cyc == 882) b882 = int'(busy1);
      if (cyc == 883) begin b883 = int'(busy1); l883 = int'(layer1); wa883 = int'(weight_addr1); end
      step();
    end
    b_end = int'(busy1);
    chk("held_done_count", done_cyc.size(), 2);
    if (done_cyc.size() == 2) begin
      chk("held_done1_cycle", done_cyc[0], 881);
      chk("held_done2_cycle", done_cyc[1], 1763);
    end
    chk("held_idle_gap_busy", b882, 0);
    chk("held_restart_busy", b883, 1);
    chk("held_restart_layer", l883, 1);
    chk("held_restart_addr", wa883, 0);
    chk("held_end_idle", b_end, 0);

    // Reset during L1 MAC at k=400
    cyc = 0; start1 = 1'b1;
    step();
    start1 = 1'b0;
    while (cyc < 401) step();
    wa401 = int'(weight_addr1);
    chk("pre_reset_addr", wa401, 400);
    reset1 = 1'b1;
    step();
    chk("post_reset_outs", outs1(), 64'd0);
    reset1 = 1'b0;
    strobe_cnt = 0;
    for (int n = 0; n < 20; n++) begin
      if (mac_en1 || bias_en1 || busy1 || done1) strobe_cnt++;
      step();
    end
    chk("post_reset_quiet", strobe_cnt, 0);

    done_at1 = 0; done_cnt1 = 0;
    cyc = 0; start1 = 1'b1;
    step();
    start1 = 1'b0;
    for (int n = 0; n < 900; n++) begin
      if (done1) begin done_cnt1++; if (done_at1 == 0) done_at1 = cyc; end
      step();
    end
    chk("fresh_done_cycle", done_at1, 881);
    chk("fresh_done_count", done_cnt1, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
